// File: rtl/serial_add_sequencer_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer: FSM state
// encodings and add/subtract opcode values.
package serial_add_sequencer_pkg;

  typedef enum logic [1:0] {
    SAS_IDLE = 2'd0,
    SAS_RUN  = 2'd1,
    SAS_DONE = 2'd2
  } sas_state_e;

  localparam logic ADD_OP = 1'b0;
  localparam logic SUB_OP = 1'b1;

endpackage

// File: rtl/serial_add_sequencer_fulladder.sv
// Single-bit full adder, time-shared by the serial add/subtract sequencer.
module fulladder (
  output logic sum,
  output logic carry,
  input  logic a,
  input  logic b,
  input  logic c
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract controller: one full adder processes one operand bit
// per RUN cycle, LSB first, over WIDTH cycles.
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

  sas_state_e       state, state_next;
  logic             accept;
  logic [CNTW-1:0]  count;
  logic             carry;
  logic [WIDTH-1:0] opa, opb, shadow;
  logic             fa_sum, fa_carry;

  fulladder u_fulladder (
    .sum   (fa_sum),
    .carry (fa_carry),
    .a     (opa[0]),
    .b     (opb[0]),
    .c     (carry)
  );

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      SAS_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SAS_RUN;
        end
      end
      SAS_RUN: begin
        if (count == LAST_BIT) state_next = SAS_DONE;
      end
      SAS_DONE: begin
        accept     = start;
        state_next = start ? SAS_RUN : SAS_IDLE;
      end
      default: state_next = SAS_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SAS_IDLE;
      count    <= '0;
      carry    <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      shadow   <= '0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        // Subtract is a + ~b + 1: invert B here and seed the carry with 1.
        opa      <= a;
        opb      <= (sub == SUB_OP) ? ~b : b;
        carry    <= sub;
        count    <= '0;
        shadow   <= '0;
        result   <= '0;
        carryout <= 1'b0;
        overflow <= 1'b0;
      end else if (state == SAS_RUN) begin
        carry  <= fa_carry;
        shadow <= {fa_sum, shadow[WIDTH-1:1]};
        opa    <= opa >> 1;
        opb    <= opb >> 1;
        count  <= count + 1'b1;
        // On the MSB cycle, the carry register holds the carry into the MSB.
        if (count == LAST_BIT) begin
          result   <= {fa_sum, shadow[WIDTH-1:1]};
          carryout <= fa_carry;
          overflow <= carry ^ fa_carry;
        end
      end
    end
  end

  assign busy = (state == SAS_RUN);
  assign done = (state == SAS_DONE);
  assign zero = (result == '0);

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench: directed WIDTH=4 scenarios plus a randomized WIDTH=32
// sweep compared against an arithmetic reference model.
module tb_serial_add_sequencer;

  logic clk = 1'b0;
  always #100 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=4 instance
  logic       rst4, start4, sub4;
  logic [3:0] a4, b4, result4;
  logic       busy4, done4, co4, ov4, zero4;

  serial_add_sequencer #(.WIDTH(4), .CNTW(3)) dut4 (
    .clk(clk), .reset(rst4), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .carryout(co4),
    .overflow(ov4), .zero(zero4)
  );

  // WIDTH=32 instance
  logic        rst32, start32, sub32;
  logic [31:0] a32, b32, result32;
  logic        busy32, done32, co32, ov32, zero32;

  serial_add_sequencer #(.WIDTH(32), .CNTW(6)) dut32 (
    .clk(clk), .reset(rst32), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(result32), .carryout(co32),
    .overflow(ov32), .zero(zero32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic and signed-sign rules.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic s, output logic [63:0] r,
                                output logic c, output logic v);
    logic [63:0] m, full;
    logic sa, sb, sr;
    m    = 64'd1 << w;
    full = s ? a + (m - b) : a + b;
    r    = full & (m - 1);
    c    = full[w];
    sa   = a[w-1];
    sb   = b[w-1];
    sr   = r[w-1];
    v    = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge; lat = edges after the accept edge until done.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s, output int lat);
    a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_res4(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic s);
    logic [63:0] r;
    logic c, v;
    model(4, {60'd0, a}, {60'd0, b}, s, r, c, v);
    check({tag, "_result"}, {60'd0, result4}, r);
    check({tag, "_carry"}, {63'd0, co4}, {63'd0, c});
    check({tag, "_ovf"}, {63'd0, ov4}, {63'd0, v});
    check({tag, "_zero"}, {63'd0, zero4}, {63'd0, (r == 0)});
  endtask

  initial begin
    int lat, n, dcount;
    logic [31:0] ra, rb;
    logic rs;
    logic [63:0] er;
    logic ec, ev;

    rst4 = 1'b1; start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    rst32 = 1'b1; start32 = 1'b0; sub32 = 1'b0; a32 = '0; b32 = '0;
    tick(); tick();
    rst4 = 1'b0; rst32 = 1'b0;

    check("rst_busy", {63'd0, busy4}, 64'd0);
    check("rst_done", {63'd0, done4}, 64'd0);
    check("rst_result", {60'd0, result4}, 64'd0);
    check("rst_carry", {63'd0, co4}, 64'd0);
    check("rst_ovf", {63'd0, ov4}, 64'd0);
    check("rst_zero", {63'd0, zero4}, 64'd1);

    // 3 + 5: latency and signed overflow into the sign bit
    a4 = 4'h3; b4 = 4'h5; sub4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("t2_busy", {63'd0, busy4}, 64'd1);
    lat = 0;
    while (!done4 && lat < 50) begin
      tick();
      lat++;
    end
    check("t2_latency", lat, 64'd4);
    check_res4("t2", 4'h3, 4'h5, 1'b0);
    check("t2_res_const", {60'd0, result4}, 64'h8);
    tick();
    check("t2_done_pulse", {63'd0, done4}, 64'd0);

    // 5 - 5: zero result, no borrow
    op4(4'h5, 4'h5, 1'b1, lat);
    check("t3_latency", lat, 64'd4);
    check_res4("t3", 4'h5, 4'h5, 1'b1);
    check("t3_zero_const", {63'd0, zero4}, 64'd1);
    tick();

    // F + 1 wraps, then start held high through DONE for back-to-back ops
    a4 = 4'hF; b4 = 4'h1; sub4 = 1'b0; start4 = 1'b1;
    tick();
    a4 = 4'h7; b4 = 4'h1;
    lat = 0;
    while (!done4 && lat < 50) begin
      tick();
      lat++;
    end
    check("t4_latency", lat, 64'd4);
    check_res4("t4a", 4'hF, 4'h1, 1'b0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done4 && n < 20);
    check("t4_b2b_period1", n, 64'd5);
    check_res4("t4b", 4'h7, 4'h1, 1'b0);
    a4 = 4'h2; b4 = 4'h3; sub4 = 1'b1;
    tick();
    a4 = 4'h0; b4 = 4'h0; sub4 = 1'b0;
    n = 1;
    while (!done4 && n < 20) begin
      tick();
      n++;
    end
    check("t4_b2b_period2", n, 64'd5);
    check_res4("t4c", 4'h2, 4'h3, 1'b1);
    start4 = 1'b0;
    tick();
    check("t4_idle_busy", {63'd0, busy4}, 64'd0);
    check("t4_idle_done", {63'd0, done4}, 64'd0);

    // start pulsed mid-RUN with other operands must be ignored
    a4 = 4'h6; b4 = 4'h1; sub4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    a4 = 4'h9; b4 = 4'h9; sub4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 2;
    while (!done4 && lat < 50) begin
      tick();
      lat++;
    end
    check("t5_latency", lat, 64'd4);
    check_res4("t5", 4'h6, 4'h1, 1'b0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done4) dcount++;
    end
    check("t5_extra_done", dcount, 64'd0);
    check("t5_result_held", {60'd0, result4}, 64'h7);

    // reset for 2 cycles mid-RUN abandons the op
    a4 = 4'h9; b4 = 4'h4; sub4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    rst4 = 1'b1;
    tick(); tick();
    rst4 = 1'b0;
    check("t1_busy", {63'd0, busy4}, 64'd0);
    check("t1_done", {63'd0, done4}, 64'd0);
    check("t1_result", {60'd0, result4}, 64'd0);
    check("t1_zero", {63'd0, zero4}, 64'd1);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done4 || busy4) dcount++;
    end
    check("t1_no_resume", dcount, 64'd0);
    op4(4'hA, 4'h3, 1'b1, lat);
    check("t1_after_latency", lat, 64'd4);
    check_res4("t1_after", 4'hA, 4'h3, 1'b1);

    // WIDTH=32 random sweep with a few corner operands first
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0:       begin ra = 32'h0000_0000; rb = 32'h0000_0000; rs = 1'b1; end
        1:       begin ra = 32'h8000_0000; rb = 32'h0000_0001; rs = 1'b1; end
        2:       begin ra = 32'h7FFF_FFFF; rb = 32'h0000_0001; rs = 1'b0; end
        3:       begin ra = 32'hFFFF_FFFF; rb = 32'h0000_0001; rs = 1'b0; end
        default: begin ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1)); end
      endcase
      a32 = ra; b32 = rb; sub32 = rs; start32 = 1'b1;
      tick();
      start32 = 1'b0;
      a32 = $urandom; b32 = $urandom;
      lat = 0;
      while (!done32 && lat < 100) begin
        tick();
        lat++;
      end
      model(32, {32'd0, ra}, {32'd0, rb}, rs, er, ec, ev);
      check("w32_latency", lat, 64'd32);
      check("w32_result", {32'd0, result32}, er);
      check("w32_carry", {63'd0, co32}, {63'd0, ec});
      check("w32_ovf", {63'd0, ov32}, {63'd0, ev});
      check("w32_zero", {63'd0, zero32}, {63'd0, (er == 0)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
